// File: rtl/axil_to_wb_bridge_if.sv
// Bus bundles for the AXI4-Lite-to-Wishbone bridge: an AXI4-Lite channel set
// and a classic Wishbone master/slave bundle.
interface axil_if #(
  parameter int unsigned ADDR_BITS = 18,
  parameter int unsigned DATA_BITS = 32
);
  logic [ADDR_BITS-1:0]   s_axi_awaddr;
  logic                   s_axi_awvalid;
  logic                   s_axi_awready;
  logic [DATA_BITS-1:0]   s_axi_wdata;
  logic [DATA_BITS/8-1:0] s_axi_wstrb;
  logic                   s_axi_wvalid;
  logic                   s_axi_wready;
  logic [1:0]             s_axi_bresp;
  logic                   s_axi_bvalid;
  logic                   s_axi_bready;
  logic [ADDR_BITS-1:0]   s_axi_araddr;
  logic                   s_axi_arvalid;
  logic                   s_axi_arready;
  logic [DATA_BITS-1:0]   s_axi_rdata;
  logic [1:0]             s_axi_rresp;
  logic                   s_axi_rvalid;
  logic                   s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

interface wb_if #(
  parameter int unsigned ADDR_BITS = 18,
  parameter int unsigned DATA_BITS = 32
);
  logic                   wbm_cyc_o;
  logic                   wbm_stb_o;
  logic                   wbm_we_o;
  logic [ADDR_BITS-1:0]   wbm_adr_o;
  logic [DATA_BITS-1:0]   wbm_dat_o;
  logic [DATA_BITS/8-1:0] wbm_sel_o;
  logic [DATA_BITS-1:0]   wbm_dat_i;
  logic                   wbm_ack_i;
  logic                   wbm_err_i;
  logic                   wbm_rty_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );
endinterface

// File: rtl/axil_to_wb_bridge.sv
// AXI4-Lite responder that runs each read or write as one classic Wishbone
// cycle, one transaction at a time, with read/write fairness and a watchdog.
module axil_to_wb_bridge #(
  parameter int unsigned ADDR_BITS = 18,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic  wb_clk_i,
  input  logic  wb_rst_i,
  axil_if.slave s_axi,
  wb_if.master  wbm
);

  localparam int unsigned STRB_BITS = DATA_BITS / 8;
  localparam int unsigned CNT_BITS  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, B_RESP, R_RESP} state_t;

  state_t state, next_state;

  logic                 aw_held, w_held, pri_rd;
  logic [ADDR_BITS-1:0] awaddr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [STRB_BITS-1:0] wstrb_q;
  logic                 cyc_q, stb_q, we_q;
  logic [ADDR_BITS-1:0] adr_q;
  logic [DATA_BITS-1:0] dat_q;
  logic [STRB_BITS-1:0] sel_q;
  logic                 bvalid_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic [CNT_BITS-1:0]  wd_cnt;

  logic       grant_wr, awready_c, wready_c, arready_c;
  logic       aw_hs, w_hs, ar_hs, wr_go, term, timeout;
  logic [1:0] resp_c;

  assign aw_hs   = s_axi.s_axi_awvalid & awready_c;
  assign w_hs    = s_axi.s_axi_wvalid  & wready_c;
  assign ar_hs   = s_axi.s_axi_arvalid & arready_c;
  assign wr_go   = (aw_held | aw_hs) & (w_held | w_hs);
  assign term    = wbm.wbm_ack_i | wbm.wbm_err_i | wbm.wbm_rty_i;
  // A termination arriving on the timeout cycle takes precedence.
  assign timeout = (wd_cnt == CNT_BITS'(TIMEOUT)) & ~term;
  assign resp_c  = wbm.wbm_ack_i ? 2'b00 : (term ? 2'b10 : 2'b11);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_go)      next_state = WB_WR;
        else if (ar_hs) next_state = WB_RD;
      end
      WB_WR:   if (term || timeout) next_state = B_RESP;
      WB_RD:   if (term || timeout) next_state = R_RESP;
      B_RESP:  if (s_axi.s_axi_bready) next_state = IDLE;
      R_RESP:  if (s_axi.s_axi_rready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Arbitration: a half-captured write finishes first, otherwise alternate.
  always_comb begin
    grant_wr  = 1'b0;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    arready_c = 1'b0;
    if (aw_held || w_held)
      grant_wr = 1'b1;
    else if ((s_axi.s_axi_awvalid || s_axi.s_axi_wvalid) && s_axi.s_axi_arvalid)
      grant_wr = ~pri_rd;
    else
      grant_wr = s_axi.s_axi_awvalid | s_axi.s_axi_wvalid;
    if (state == IDLE) begin
      awready_c = grant_wr & ~aw_held;
      wready_c  = grant_wr & ~w_held;
      arready_c = ~grant_wr;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      pri_rd   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= s_axi.s_axi_awaddr;
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s_axi.s_axi_wdata;
            wstrb_q <= s_axi.s_axi_wstrb;
          end
          // Launch straight from whichever half arrives last.
          if (wr_go) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b1;
            adr_q <= aw_held ? awaddr_q : s_axi.s_axi_awaddr;
            dat_q <= w_held ? wdata_q : s_axi.s_axi_wdata;
            sel_q <= w_held ? wstrb_q : s_axi.s_axi_wstrb;
          end else if (ar_hs) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= s_axi.s_axi_araddr;
            sel_q <= '1;
          end
        end
        WB_WR, WB_RD: begin
          wd_cnt <= wd_cnt + CNT_BITS'(1);
          if (term || timeout) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            if (state == WB_WR) begin
              bvalid_q <= 1'b1;
              bresp_q  <= resp_c;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= resp_c;
              rdata_q  <= wbm.wbm_ack_i ? wbm.wbm_dat_i : '0;
            end
          end
        end
        B_RESP: begin
          if (s_axi.s_axi_bready) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            pri_rd   <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi.s_axi_rready) begin
            rvalid_q <= 1'b0;
            pri_rd   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi.s_axi_awready = awready_c;
  assign s_axi.s_axi_wready  = wready_c;
  assign s_axi.s_axi_arready = arready_c;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign s_axi.s_axi_rdata   = rdata_q;

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;

endmodule
